// File: rtl/multi_bank_cmd_scheduler_pkg.sv
// Shared types and helpers for the multi-bank command scheduler: bank states,
// scheduler commands, the packed per-bank info word and arbitration classes.
package multi_bank_cmd_scheduler_pkg;

    localparam int ADDR_BITS = 16;
    localparam int BA_BITS   = 4;

    typedef enum logic [3:0] {
        B_IDLE          = 4'd0,
        B_ACTIVE        = 4'd1,
        B_ACT_STANDBY   = 4'd2,
        B_READ          = 4'd3,
        B_READ_CHECK    = 4'd4,
        B_WRITE         = 4'd5,
        B_WRITE_CHECK   = 4'd6,
        B_READA         = 4'd7,
        B_WRITEA        = 4'd8,
        B_PRE           = 4'd9,
        B_REFRESH_CHECK = 4'd10
    } bank_state_t;

    typedef enum logic [2:0] {
        ATCMD_NOP     = 3'd0,
        ATCMD_ACTIVE  = 3'd1,
        ATCMD_READ    = 3'd2,
        ATCMD_WRITE   = 3'd3,
        ATCMD_READA   = 3'd4,
        ATCMD_WRITEA  = 3'd5,
        ATCMD_PRE     = 3'd6,
        ATCMD_REFRESH = 3'd7
    } sch_cmd_t;

    typedef enum logic {
        RW_READ  = 1'b0,
        RW_WRITE = 1'b1
    } r_w_t;

    typedef struct packed {
        bank_state_t          state;
        logic [ADDR_BITS-1:0] addr;
    } bank_info_t;

    typedef enum logic [2:0] {
        RC_NONE, RC_REF, RC_AGED, RC_PRE, RC_COL_CUR, RC_COL_OPP, RC_ACT
    } req_class_t;

    localparam int BA_INFO_WIDTH  = $bits(bank_info_t);
    localparam int ISU_FIFO_WIDTH = $bits(sch_cmd_t) + ADDR_BITS + BA_BITS;

    function automatic sch_cmd_t decode_req(input bank_state_t s);
        case (s)
            B_ACTIVE:        return ATCMD_ACTIVE;
            B_READ:          return ATCMD_READ;
            B_WRITE:         return ATCMD_WRITE;
            B_PRE:           return ATCMD_PRE;
            B_READA:         return ATCMD_READA;
            B_WRITEA:        return ATCMD_WRITEA;
            B_REFRESH_CHECK: return ATCMD_REFRESH;
            default:         return ATCMD_NOP;
        endcase
    endfunction

    // Banks with nothing in flight do not accumulate age; unknown encodings count as idle.
    function automatic logic age_hold_clear(input bank_state_t s);
        case (s)
            B_ACTIVE, B_READ, B_READ_CHECK, B_WRITE, B_WRITE_CHECK,
            B_READA, B_WRITEA, B_PRE, B_REFRESH_CHECK: return 1'b0;
            default:                                   return 1'b1;
        endcase
    endfunction

    function automatic logic is_col(input sch_cmd_t c);
        return (c == ATCMD_READ) || (c == ATCMD_READA) ||
               (c == ATCMD_WRITE) || (c == ATCMD_WRITEA);
    endfunction

    function automatic r_w_t col_dir(input sch_cmd_t c);
        return ((c == ATCMD_READ) || (c == ATCMD_READA)) ? RW_READ : RW_WRITE;
    endfunction

endpackage

// File: rtl/multi_bank_cmd_scheduler_bank_age_counter.sv
// Saturating per-bank age counter; a grant or an idle bank state clears it.
module bank_age_counter #(
    parameter int AGE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold_clear,
    input  logic                 grant_clear,
    output logic [AGE_WIDTH-1:0] age
);

    logic [AGE_WIDTH-1:0] age_q;
    logic [AGE_WIDTH-1:0] age_d;

    always_comb begin
        age_d = age_q;
        if (grant_clear || hold_clear) begin
            age_d = '0;
        end else if (age_q != '1) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) age_q <= '0;
        else     age_q <= age_d;
    end

    assign age = age_q;

endmodule

// File: rtl/multi_bank_cmd_scheduler.sv
// Arbitrates NUM_BANKS bank FSMs into one issue stream with age-based starvation
// override, read/write grouping and tRRD/tFAW activate spacing.
module multi_bank_cmd_scheduler
    import multi_bank_cmd_scheduler_pkg::*;
#(
    parameter int NUM_BANKS     = 8,
    parameter int AGE_WIDTH     = 8,
    parameter int AGE_THRESHOLD = 16,
    parameter int RW_BURST_MAX  = 4,
    parameter int TRRD          = 4,
    parameter int ACT_WINDOW    = 4,
    parameter int FAW_CYCLES    = 20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               isu_fifo_full,
    input  logic [NUM_BANKS*BA_INFO_WIDTH-1:0] ba_info,
    output logic [NUM_BANKS-1:0]               ba_stall,
    output logic [ISU_FIFO_WIDTH-1:0]          sch_out,
    output logic                               sch_issue
);

    localparam int IDX_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int BURST_W = $clog2(RW_BURST_MAX + 1);
    localparam int TRRD_W  = (TRRD > 1) ? $clog2(TRRD) : 1;
    // The current cycle is the last slot of the window, so only FAW_CYCLES-1 past cycles are kept.
    localparam int HIST_W  = (FAW_CYCLES > 1) ? FAW_CYCLES - 1 : 1;

    bank_info_t                 info_w   [NUM_BANKS];
    sch_cmd_t                   req_cmd_w[NUM_BANKS];
    logic [AGE_WIDTH-1:0]       age_w    [NUM_BANKS];
    logic [NUM_BANKS-1:0]       req_valid_w, hold_clear_w, grant_onehot;
    logic [NUM_BANKS-1:0]       ref_m, aged_m, pre_m, cur_m, opp_m, act_m, sel_m;
    req_class_t                 sel_class;
    logic                       act_blocked, found, grant_valid;
    logic [IDX_W-1:0]           win_idx, cand_idx;
    logic [AGE_WIDTH-1:0]       best_age;
    sch_cmd_t                   win_cmd;
    int                         act_cnt;

    logic                       issue_q, issue_d;
    logic [ISU_FIFO_WIDTH-1:0]  out_q, out_d;
    logic [IDX_W-1:0]           rr_q, rr_d;
    r_w_t                       dir_q, dir_d;
    logic [BURST_W-1:0]         burst_q, burst_d;
    logic [TRRD_W-1:0]          trrd_q, trrd_d;
    logic [HIST_W-1:0]          hist_q, hist_d;

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        assign info_w[gi]       = bank_info_t'(ba_info[gi*BA_INFO_WIDTH +: BA_INFO_WIDTH]);
        assign req_cmd_w[gi]    = decode_req(info_w[gi].state);
        assign hold_clear_w[gi] = age_hold_clear(info_w[gi].state);
        assign req_valid_w[gi]  = (req_cmd_w[gi] != ATCMD_NOP) &&
                                  !((req_cmd_w[gi] == ATCMD_ACTIVE) && act_blocked);

        bank_age_counter #(.AGE_WIDTH(AGE_WIDTH)) u_age (
            .clk         (clk),
            .rst         (rst),
            .hold_clear  (hold_clear_w[gi]),
            .grant_clear (grant_onehot[gi]),
            .age         (age_w[gi])
        );
    end

    always_comb begin
        act_cnt = 0;
        if (FAW_CYCLES > 1) begin
            for (int i = 0; i < HIST_W; i++) act_cnt += int'(hist_q[i]);
        end
    end

    assign act_blocked = (trrd_q != '0) || (act_cnt >= ACT_WINDOW);

    always_comb begin
        ref_m = '0; aged_m = '0; pre_m = '0; cur_m = '0; opp_m = '0; act_m = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (req_valid_w[i]) begin
                if (req_cmd_w[i] == ATCMD_REFRESH)             ref_m[i]  = 1'b1;
                else if (int'(age_w[i]) > AGE_THRESHOLD)       aged_m[i] = 1'b1;
                else if (req_cmd_w[i] == ATCMD_PRE)            pre_m[i]  = 1'b1;
                else if (is_col(req_cmd_w[i])) begin
                    if (col_dir(req_cmd_w[i]) == dir_q)        cur_m[i]  = 1'b1;
                    else                                       opp_m[i]  = 1'b1;
                end else                                       act_m[i]  = 1'b1;
            end
        end

        sel_class = RC_NONE;
        if (|ref_m)                                                 sel_class = RC_REF;
        else if (|aged_m)                                           sel_class = RC_AGED;
        else if (|pre_m)                                            sel_class = RC_PRE;
        else if ((burst_q == BURST_W'(RW_BURST_MAX)) && (|opp_m))   sel_class = RC_COL_OPP;
        else if (|cur_m)                                            sel_class = RC_COL_CUR;
        else if (|opp_m)                                            sel_class = RC_COL_OPP;
        else if (|act_m)                                            sel_class = RC_ACT;

        case (sel_class)
            RC_REF:     sel_m = ref_m;
            RC_AGED:    sel_m = aged_m;
            RC_PRE:     sel_m = pre_m;
            RC_COL_CUR: sel_m = cur_m;
            RC_COL_OPP: sel_m = opp_m;
            RC_ACT:     sel_m = act_m;
            default:    sel_m = '0;
        endcase

        // Scan in round-robin order; strict '>' keeps the earliest bank on an age tie.
        found    = 1'b0;
        win_idx  = '0;
        cand_idx = '0;
        best_age = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            cand_idx = rr_q + IDX_W'(k);
            if (sel_m[cand_idx] && (!found || (age_w[cand_idx] > best_age))) begin
                found    = 1'b1;
                win_idx  = cand_idx;
                best_age = age_w[cand_idx];
            end
        end

        grant_valid  = found && !isu_fifo_full && !rst;
        win_cmd      = req_cmd_w[win_idx];
        grant_onehot = '0;
        if (grant_valid) grant_onehot[win_idx] = 1'b1;
    end

    always_comb begin
        issue_d = grant_valid;
        out_d   = out_q;
        rr_d    = rr_q;
        dir_d   = dir_q;
        burst_d = burst_q;
        trrd_d  = (trrd_q != '0) ? trrd_q - 1'b1 : trrd_q;
        hist_d  = hist_q << 1;
        if (grant_valid) begin
            out_d = {win_cmd, info_w[win_idx].addr, BA_BITS'(win_idx)};
            rr_d  = win_idx + 1'b1;
            if (is_col(win_cmd)) begin
                if (col_dir(win_cmd) == dir_q) begin
                    if (burst_q != BURST_W'(RW_BURST_MAX)) burst_d = burst_q + 1'b1;
                end else begin
                    dir_d   = col_dir(win_cmd);
                    burst_d = BURST_W'(1);
                end
            end
            if (win_cmd == ATCMD_ACTIVE) begin
                trrd_d    = TRRD_W'(TRRD - 1);
                hist_d[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_q <= 1'b0;
            out_q   <= '0;
            rr_q    <= '0;
            dir_q   <= RW_WRITE;
            burst_q <= '0;
            trrd_q  <= '0;
            hist_q  <= '0;
        end else begin
            issue_q <= issue_d;
            out_q   <= out_d;
            rr_q    <= rr_d;
            dir_q   <= dir_d;
            burst_q <= burst_d;
            trrd_q  <= trrd_d;
            hist_q  <= hist_d;
        end
    end

    assign ba_stall  = ~grant_onehot;
    assign sch_issue = issue_q;
    assign sch_out   = out_q;

endmodule

// File: tb/tb_multi_bank_cmd_scheduler.sv
// Directed bench for multi_bank_cmd_scheduler: reset, ACT spacing, direction
// grouping, FIFO back-pressure and starvation override with mid-run reset.
module tb_multi_bank_cmd_scheduler;
    import multi_bank_cmd_scheduler_pkg::*;

    localparam int NB = 8;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          isu_fifo_full;
    logic [NB*BA_INFO_WIDTH-1:0]   ba_info;
    logic [NB-1:0]                 ba_stall;
    logic [ISU_FIFO_WIDTH-1:0]     sch_out;
    logic                          sch_issue;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_bank_cmd_scheduler #(
        .NUM_BANKS(NB), .AGE_WIDTH(8), .AGE_THRESHOLD(16), .RW_BURST_MAX(4),
        .TRRD(4), .ACT_WINDOW(4), .FAW_CYCLES(20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .isu_fifo_full (isu_fifo_full),
        .ba_info       (ba_info),
        .ba_stall      (ba_stall),
        .sch_out       (sch_out),
        .sch_issue     (sch_issue)
    );

    task automatic set_bank(input int b, input bank_state_t s, input logic [ADDR_BITS-1:0] a);
        ba_info[b*BA_INFO_WIDTH +: BA_INFO_WIDTH] = {s, a};
    endtask

    function automatic logic [ISU_FIFO_WIDTH-1:0] mk_out(input sch_cmd_t c,
                                                         input logic [ADDR_BITS-1:0] a, input int b);
        return {c, a, BA_BITS'(b)};
    endfunction

    function automatic logic [NB-1:0] stall_for(input int b);
        logic [NB-1:0] m;
        m = '1;
        m[b] = 1'b0;
        return m;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        isu_fifo_full = 1'b0;
        ba_info = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sch_issue !== 1'b0) begin errors++; $display("FAIL reset_issue got=%b exp=0", sch_issue); end
        checks++; if (sch_out !== '0) begin errors++; $display("FAIL reset_out got=%h exp=0", sch_out); end
        @(negedge clk);
        checks++; if (ba_stall !== 8'hFF) begin errors++; $display("FAIL reset_stall got=%b exp=11111111", ba_stall); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_act();
        logic [ISU_FIFO_WIDTH-1:0] exp;
        do_reset();
        exp = mk_out(ATCMD_ACTIVE, 16'h1234, 2);
        set_bank(2, B_ACTIVE, 16'h1234);
        @(negedge clk);
        checks++; if (ba_stall !== 8'b1111_1011) begin errors++; $display("FAIL single_stall got=%b exp=11111011", ba_stall); end
        @(posedge clk); #1;
        set_bank(2, B_ACT_STANDBY, 16'h1234);
        $display("txn single issue=%b out=%h", sch_issue, sch_out);
        checks++; if (sch_issue !== 1'b1) begin errors++; $display("FAIL single_issue got=%b exp=1", sch_issue); end
        checks++; if (sch_out !== exp) begin errors++; $display("FAIL single_out got=%h exp=%h", sch_out, exp); end
        @(negedge clk);
        checks++; if (ba_stall !== 8'hFF) begin errors++; $display("FAIL single_idle_stall got=%b exp=11111111", ba_stall); end
        @(posedge clk); #1;
        checks++; if (sch_issue !== 1'b0) begin errors++; $display("FAIL single_noissue got=%b exp=0", sch_issue); end
        checks++; if (sch_out !== exp) begin errors++; $display("FAIL single_hold got=%h exp=%h", sch_out, exp); end
    endtask

    task automatic test_act_timing();
        int nxt;
        logic exp_g;
        logic [NB-1:0] exp_stall;
        do_reset();
        for (int b = 0; b < 5; b++) set_bank(b, B_ACTIVE, ADDR_BITS'(16'h0100 + b));
        nxt = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            exp_g = (cyc == 0) || (cyc == 4) || (cyc == 8) || (cyc == 12) || (cyc == 20);
            exp_stall = exp_g ? stall_for(nxt) : 8'hFF;
            @(negedge clk);
            checks++;
            if (ba_stall !== exp_stall) begin
                errors++; $display("FAIL act_stall cyc=%0d got=%b exp=%b", cyc, ba_stall, exp_stall);
            end
            @(posedge clk); #1;
            if (exp_g) begin
                set_bank(nxt, B_ACT_STANDBY, ADDR_BITS'(16'h0100 + nxt));
                $display("txn act cyc=%0d issue=%b out=%h", cyc, sch_issue, sch_out);
                checks++;
                if (sch_issue !== 1'b1 || sch_out !== mk_out(ATCMD_ACTIVE, ADDR_BITS'(16'h0100 + nxt), nxt)) begin
                    errors++; $display("FAIL act_out cyc=%0d got=%b/%h exp=1/%h", cyc, sch_issue, sch_out,
                                       mk_out(ATCMD_ACTIVE, ADDR_BITS'(16'h0100 + nxt), nxt));
                end
                nxt++;
            end else begin
                checks++;
                if (sch_issue !== 1'b0) begin errors++; $display("FAIL act_gap cyc=%0d got=%b exp=0", cyc, sch_issue); end
            end
        end
    endtask

    task automatic test_rw_grouping();
        int       exp_bank [7] = '{0, 1, 0, 1, 5, 0, 1};
        sch_cmd_t exp_cmd  [7] = '{ATCMD_WRITE, ATCMD_WRITE, ATCMD_WRITE, ATCMD_WRITE,
                                   ATCMD_READ, ATCMD_WRITE, ATCMD_WRITE};
        logic [ISU_FIFO_WIDTH-1:0] exp;
        do_reset();
        set_bank(0, B_WRITE, 16'h00A0);
        set_bank(1, B_WRITE, 16'h00A1);
        set_bank(5, B_READ,  16'h00A5);
        for (int t = 0; t < 7; t++) begin
            exp = mk_out(exp_cmd[t], ADDR_BITS'(16'h00A0 + exp_bank[t]), exp_bank[t]);
            @(negedge clk);
            checks++;
            if (ba_stall !== stall_for(exp_bank[t])) begin
                errors++; $display("FAIL rw_stall t=%0d got=%b exp=%b", t, ba_stall, stall_for(exp_bank[t]));
            end
            @(posedge clk); #1;
            if (exp_bank[t] == 5) set_bank(5, B_IDLE, 16'h00A5);
            $display("txn rw t=%0d issue=%b out=%h", t, sch_issue, sch_out);
            checks++;
            if (sch_issue !== 1'b1 || sch_out !== exp) begin
                errors++; $display("FAIL rw_out t=%0d got=%b/%h exp=1/%h", t, sch_issue, sch_out, exp);
            end
        end
        ba_info = '0;
    endtask

    task automatic test_fifo_full();
        logic [ISU_FIFO_WIDTH-1:0] exp;
        do_reset();
        isu_fifo_full = 1'b1;
        set_bank(3, B_PRE, 16'h0033);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (ba_stall !== 8'hFF) begin errors++; $display("FAIL full_stall c=%0d got=%b exp=11111111", c, ba_stall); end
            @(posedge clk); #1;
            checks++; if (sch_issue !== 1'b0) begin errors++; $display("FAIL full_issue c=%0d got=%b exp=0", c, sch_issue); end
        end
        isu_fifo_full = 1'b0;
        @(negedge clk);
        checks++; if (ba_stall !== 8'b1111_0111) begin errors++; $display("FAIL full_release_stall got=%b exp=11110111", ba_stall); end
        @(posedge clk); #1;
        set_bank(3, B_IDLE, 16'h0033);
        exp = mk_out(ATCMD_PRE, 16'h0033, 3);
        $display("txn full_release issue=%b out=%h", sch_issue, sch_out);
        checks++; if (sch_issue !== 1'b1 || sch_out !== exp) begin errors++; $display("FAIL full_release_out got=%b/%h exp=1/%h", sch_issue, sch_out, exp); end
    endtask

    task automatic test_starvation();
        logic [ISU_FIFO_WIDTH-1:0] exp;
        do_reset();
        set_bank(6, B_READ_CHECK, 16'h0066);
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            checks++; if (ba_stall !== 8'hFF) begin errors++; $display("FAIL starve_wait_stall c=%0d got=%b exp=11111111", c, ba_stall); end
            @(posedge clk); #1;
        end
        set_bank(6, B_ACTIVE, 16'h0066);
        set_bank(1, B_PRE, 16'h0011);
        set_bank(0, B_REFRESH_CHECK, 16'h0000);
        @(negedge clk);
        checks++; if (ba_stall !== 8'b1111_1110) begin errors++; $display("FAIL starve_ref_stall got=%b exp=11111110", ba_stall); end
        @(posedge clk); #1;
        set_bank(0, B_IDLE, 16'h0000);
        exp = mk_out(ATCMD_REFRESH, 16'h0000, 0);
        $display("txn starve_ref issue=%b out=%h", sch_issue, sch_out);
        checks++; if (sch_issue !== 1'b1 || sch_out !== exp) begin errors++; $display("FAIL starve_ref_out got=%b/%h exp=1/%h", sch_issue, sch_out, exp); end
        @(negedge clk);
        checks++; if (ba_stall !== 8'b1011_1111) begin errors++; $display("FAIL starve_act_stall got=%b exp=10111111", ba_stall); end
        @(posedge clk); #1;
        set_bank(6, B_ACT_STANDBY, 16'h0066);
        rst = 1'b1;
        exp = mk_out(ATCMD_ACTIVE, 16'h0066, 6);
        $display("txn starve_act issue=%b out=%h", sch_issue, sch_out);
        checks++; if (sch_issue !== 1'b1 || sch_out !== exp) begin errors++; $display("FAIL starve_act_out got=%b/%h exp=1/%h", sch_issue, sch_out, exp); end
        @(negedge clk);
        checks++; if (ba_stall !== 8'hFF) begin errors++; $display("FAIL rst_stall got=%b exp=11111111", ba_stall); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (sch_issue !== 1'b0 || sch_out !== '0) begin errors++; $display("FAIL rst_out got=%b/%h exp=0/0", sch_issue, sch_out); end
        @(negedge clk);
        checks++; if (ba_stall !== 8'b1111_1101) begin errors++; $display("FAIL post_rst_pre_stall got=%b exp=11111101", ba_stall); end
        @(posedge clk); #1;
        set_bank(1, B_IDLE, 16'h0011);
        exp = mk_out(ATCMD_PRE, 16'h0011, 1);
        $display("txn post_rst_pre issue=%b out=%h", sch_issue, sch_out);
        checks++; if (sch_issue !== 1'b1 || sch_out !== exp) begin errors++; $display("FAIL post_rst_pre_out got=%b/%h exp=1/%h", sch_issue, sch_out, exp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        isu_fifo_full = 1'b0;
        ba_info = '0;
        test_reset();
        test_single_act();
        test_act_timing();
        test_rw_grouping();
        test_fifo_full();
        test_starvation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
